// File: rtl/fifo_ctrl_pkg.sv
// Shared types and helpers for the FIFO read-side controller and its register buffer.
package fifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } rd_state_e;

    localparam int RD_LAT_SDP = 3;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_fifo_buf.sv
// Register-based circular buffer holding words returned by the FIFO until the stream consumer takes them.
module reg_fifo_buf
    import fifo_ctrl_pkg::*;
#(
    parameter int DW        = 18,
    parameter int BUF_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [DW-1:0]                din,
    output logic [DW-1:0]                head,
    output logic [cnt_w(BUF_DEPTH)-1:0]  occ
);

    localparam int CW = cnt_w(BUF_DEPTH);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DW-1:0] mem [BUF_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop & (occ != '0);
    assign do_push = push & ((occ != CW'(BUF_DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/sync_fifo_rd_ctrl.sv
// Read-side controller: issues credit-limited FIFO reads, buffers the fixed-latency returns
// and presents them as a valid/ready stream with enable and flush sequencing.
module sync_fifo_rd_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DW        = 18,
    parameter int PTR       = 15,
    parameter int RD_LAT    = RD_LAT_SDP,
    parameter int BUF_DEPTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rd_en,
    input  logic           flush,
    input  logic           fifo_empty,
    input  logic [PTR:0]   fifo_data_avail,
    output logic           fifo_ren,
    input  logic           fifo_dout_valid,
    input  logic [DW-1:0]  fifo_dout,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [DW-1:0]  m_data,
    output logic           busy,
    output logic [PTR:0]   stat_avail,
    output logic           ovf_err
);

    localparam int CW = cnt_w(BUF_DEPTH);

    // Shallower buffers stay correct through the credit check but cannot sustain one word per cycle.
    if (BUF_DEPTH < RD_LAT + 2) begin : g_reduced_rate
    end

    rd_state_e     state;
    logic [CW-1:0] inflight;
    logic [CW-1:0] occ;
    logic [CW:0]   credits_used;
    logic          accepted;
    logic          push;
    logic          pop;
    logic          ret;

    // Credits count both buffered and in-flight words, so a same-cycle pop frees a slot only next cycle.
    assign credits_used = {1'b0, occ} + {1'b0, inflight};
    assign fifo_ren     = (state == RUN) & ~fifo_empty & (credits_used < (CW + 1)'(BUF_DEPTH));
    assign accepted     = fifo_ren;
    assign ret          = fifo_dout_valid & (inflight != '0);

    assign m_valid = (occ != '0);
    assign pop     = m_valid & m_ready;
    assign push    = fifo_dout_valid & (state != FLUSH);
    assign busy    = (inflight != '0) | (occ != '0);

    reg_fifo_buf #(
        .DW        (DW),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .din   (fifo_dout),
        .head  (m_data),
        .occ   (occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            inflight   <= '0;
            stat_avail <= '0;
            ovf_err    <= 1'b0;
        end else begin
            case ({accepted, ret})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            stat_avail <= fifo_data_avail + (PTR + 1)'(occ) + (PTR + 1)'(inflight);

            if (push && !flush && (occ == CW'(BUF_DEPTH)) && !pop) begin
                ovf_err <= 1'b1;
            end

            if (flush) begin
                state <= FLUSH;
            end else begin
                case (state)
                    IDLE:    if (rd_en) state <= RUN;
                    RUN:     if (!rd_en) state <= IDLE;
                    FLUSH:   if (inflight == '0) state <= rd_en ? RUN : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_rd_ctrl.sv
// Randomized scoreboard bench: a behavioural FIFO records every word it hands out, and the
// stream monitor expects those words back in order, minus whatever a flush threw away.
module tb_sync_fifo_rd_ctrl;
    import fifo_ctrl_pkg::*;

    localparam int DW        = 18;
    localparam int PTR       = 15;
    localparam int RD_LAT    = 3;
    localparam int BUF_DEPTH = 8;

    logic           clk;
    logic           rst;
    logic           rd_en;
    logic           flush;
    logic           fifo_empty;
    logic [PTR:0]   fifo_data_avail;
    logic           fifo_ren;
    logic           fifo_dout_valid;
    logic [DW-1:0]  fifo_dout;
    logic           m_valid;
    logic           m_ready;
    logic [DW-1:0]  m_data;
    logic           busy;
    logic [PTR:0]   stat_avail;
    logic           ovf_err;

    int n_vec = 0;
    int n_err = 0;
    int delivered = 0;
    int accepted_total = 0;
    int dropped_total = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic [RD_LAT-1:0] pipe_v;
    logic [DW-1:0]     pipe_d [RD_LAT];

    sync_fifo_rd_ctrl #(
        .DW        (DW),
        .PTR       (PTR),
        .RD_LAT    (RD_LAT),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .flush           (flush),
        .fifo_empty      (fifo_empty),
        .fifo_data_avail (fifo_data_avail),
        .fifo_ren        (fifo_ren),
        .fifo_dout_valid (fifo_dout_valid),
        .fifo_dout       (fifo_dout),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .busy            (busy),
        .stat_avail      (stat_avail),
        .ovf_err         (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // FIFO with a fixed read latency; every word it hands out becomes an expected stream word.
    assign fifo_dout_valid = pipe_v[RD_LAT-1];
    assign fifo_dout       = pipe_d[RD_LAT-1];

    always @(posedge clk) begin : fifo_model
        logic [DW-1:0] w;
        if (rst) begin
            fifo_q.delete();
            exp_q.delete();
            pipe_v          <= '0;
            fifo_empty      <= 1'b1;
            fifo_data_avail <= '0;
        end else begin
            pipe_v <= {pipe_v[RD_LAT-2:0], 1'b0};
            for (int i = 1; i < RD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
            if (fifo_ren && !fifo_empty) begin
                w = fifo_q.pop_front();
                pipe_v[0] <= 1'b1;
                pipe_d[0] <= w;
                exp_q.push_back(w);
                accepted_total++;
            end
            if (flush) begin
                dropped_total += exp_q.size();
                exp_q.delete();
            end
            fifo_empty      <= (fifo_q.size() == 0);
            fifo_data_avail <= (PTR + 1)'(fifo_q.size());
        end
    end

    always @(negedge clk) begin : stream_monitor
        if (!rst) begin
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL stream_unexpected: got %0h, want no word", m_data);
                end else begin
                    checkOutput("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
                end
                delivered++;
            end
            checkOutput("ovf_err", 32'(ovf_err), 32'(0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rd, input logic fl, input logic rdy);
        rd_en   = rd;
        flush   = fl;
        m_ready = rdy;
        tick();
    endtask

    task automatic loadWords(input int base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        rd_en   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        while (!(fifo_q.size() == 0 && fifo_empty && !busy && pipe_v == '0) && k < 300) begin
            tick();
            k++;
        end
        checkOutput({name, "_drain_timeout"}, 32'(k < 300), 32'(1));
        checkOutput({name, "_leftover"}, 32'(exp_q.size()), 32'(0));
        tick();
        tick();
        checkOutput({name, "_stat_zero"}, 32'(stat_avail), 32'(0));
    endtask

    initial begin : stimulus
        int found;
        int a0;
        int d0;
        int x0;
        int k;
        int rand_base;

        rst     = 1'b1;
        rd_en   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset while words are buffered and in flight.
        loadWords(500, 20);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)));
        rd_en = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        checkOutput("rst_m_valid", 32'(m_valid), 32'(0));
        checkOutput("rst_fifo_ren", 32'(fifo_ren), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_stat_avail", 32'(stat_avail), 32'(0));
        checkOutput("rst_ovf_err", 32'(ovf_err), 32'(0));
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // Single word: latency ren -> m_valid is RD_LAT+1.
        fifo_q.push_back(DW'(18'h155));
        rd_en   = 1'b1;
        m_ready = 1'b1;
        found   = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            if (fifo_ren && !fifo_empty) found = 1;
            else tick();
        end
        checkOutput("single_ren_seen", 32'(found), 32'(1));
        for (int i = 1; i <= 5; i++) begin
            tick();
            checkOutput("single_m_valid", 32'(m_valid), 32'(i == RD_LAT + 1));
            checkOutput("single_busy", 32'(busy), 32'(i <= RD_LAT + 1));
            if (i == RD_LAT + 1) checkOutput("single_m_data", 32'(m_data), 32'(18'h155));
            if (i == 1) checkOutput("single_no_second_ren", 32'(fifo_ren), 32'(0));
        end
        drain("single");

        // Throughput: 20 words back-to-back.
        loadWords(0, 20);
        k = 0;
        while (!m_valid && k < 20) begin
            tick();
            k++;
        end
        checkOutput("tput_start", 32'(m_valid), 32'(1));
        for (int i = 0; i < 20; i++) begin
            checkOutput("tput_valid", 32'(m_valid), 32'(1));
            checkOutput("tput_data", 32'(m_data), 32'(i));
            tick();
        end
        checkOutput("tput_end", 32'(m_valid), 32'(0));
        drain("tput");

        // Backpressure: credits cap reads at BUF_DEPTH.
        m_ready = 1'b0;
        a0 = accepted_total;
        loadWords(100, 20);
        repeat (20) tick();
        checkOutput("bp_accepted", 32'(accepted_total - a0), 32'(BUF_DEPTH));
        checkOutput("bp_ren_off", 32'(fifo_ren), 32'(0));
        checkOutput("bp_data_avail", 32'(fifo_data_avail), 32'(20 - BUF_DEPTH));
        checkOutput("bp_stat_avail", 32'(stat_avail), 32'(20));
        checkOutput("bp_m_valid", 32'(m_valid), 32'(1));
        checkOutput("bp_m_data", 32'(m_data), 32'(100));
        tick();
        checkOutput("bp_hold_data", 32'(m_data), 32'(100));
        d0 = delivered;
        m_ready = 1'b1;
        k = 0;
        while (delivered - d0 < 20 && k < 80) begin
            tick();
            k++;
        end
        checkOutput("bp_delivered", 32'(delivered - d0), 32'(20));
        drain("bp");

        // Flush after five words: buffered and in-flight words vanish, nothing else is lost.
        d0 = delivered;
        x0 = dropped_total;
        loadWords(200, 20);
        k = 0;
        while (delivered - d0 < 5 && k < 200) begin
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)));
            k++;
        end
        checkOutput("flush_pre_words", 32'(delivered - d0 >= 5), 32'(1));
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("flush_m_valid", 32'(m_valid), 32'(0));
        checkOutput("flush_state", 32'(dut.state), 32'(FLUSH));
        k = 0;
        while (!(fifo_q.size() == 0 && fifo_empty && !busy && pipe_v == '0) && k < 300) begin
            applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)));
            k++;
        end
        checkOutput("flush_conservation", 32'((delivered - d0) + (dropped_total - x0)), 32'(20));
        drain("flush");

        // Enable gating: reads stop at once, landed words still come out.
        d0 = delivered;
        loadWords(300, 20);
        repeat (6) applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("gate_ren_off", 32'(fifo_ren), 32'(0));
        for (int i = 0; i < 8; i++) begin
            checkOutput("gate_ren_held", 32'(fifo_ren), 32'(0));
            applyStimulus(1'b0, 1'b0, 1'b1);
        end
        checkOutput("gate_idle_busy", 32'(busy), 32'(0));
        checkOutput("gate_all_landed", 32'(exp_q.size()), 32'(0));
        drain("gate");
        checkOutput("gate_delivered", 32'(delivered - d0), 32'(20));

        // Random traffic with refills, stalls, enable drops and occasional flushes.
        rand_base = 1000;
        for (int i = 0; i < 800; i++) begin
            if (fifo_q.size() < 4 && $urandom_range(3) == 0) begin
                k = 1 + $urandom_range(12);
                loadWords(rand_base, k);
                rand_base += k;
            end
            applyStimulus(1'($urandom_range(7) != 0), 1'($urandom_range(59) == 0),
                          1'($urandom_range(2) != 0));
        end
        drain("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_rd_ctrl.md
Name: sync_fifo_rd_ctrl

Overview:
Read-side controller for the team's synchronous block-RAM FIFO.
- The FIFO read path has a fixed multi-cycle latency (ren to dout_valid) and cannot be back-pressured once a read is issued.
- This block issues FIFO reads against a credit count, captures returning words in a small register buffer, and presents them as a valid/ready stream.
- Also provides enable and flush sequencing.
- Sits between the FIFO's read port and any downstream consumer that stalls.

Parameters:
- DW, 18, data width; equals the FIFO's data width.
- PTR, 15, FIFO address width; data-available input is PTR+1 bits.
- RD_LAT, 3, cycles from accepted fifo_ren to fifo_dout_valid.
- BUF_DEPTH, 8, skid-buffer entries; must be >= RD_LAT+2 for full throughput, >= 2 legal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_en  in  1  level; permit issuing FIFO reads
- flush  in  1  pulse; discard buffered and in-flight data
- fifo_empty  in  1  FIFO empty flag (registered in FIFO)
- fifo_data_avail  in  PTR+1  FIFO occupancy (status only, passed to stat_avail)
- fifo_ren  out  1  FIFO read request
- fifo_dout_valid  in  1  FIFO read data valid
- fifo_dout  in  DW  FIFO read data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_data  out  DW  stream data
- busy  out  1  in-flight reads or buffered words exist
- stat_avail  out  PTR+1  fifo_data_avail + buffered + in-flight, registered
- ovf_err  out  1  sticky: fifo_dout_valid arrived with buffer full

Behaviour:
Clock and reset:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: fifo_ren=0, m_valid=0, busy=0, stat_avail=0, ovf_err=0, state=IDLE, counters=0.
- m_data is undefined while m_valid=0; the bench must not check it then.

Counters:
- inflight: reads accepted but not yet returned, width $clog2(BUF_DEPTH+1).
- occ: words in buffer, same width.
- A read is accepted when fifo_ren & ~fifo_empty. A ren issued while empty is dropped by the FIFO and is not counted.
- inflight += accepted, -= fifo_dout_valid (both same cycle: unchanged).
- occ += (fifo_dout_valid & state!=FLUSH), -= (m_valid & m_ready).

Read issue:
- fifo_ren = (state==RUN) & ~fifo_empty & (occ + inflight < BUF_DEPTH).
- It is a function of registered state and fifo_empty only. It has no combinational path from m_ready; a same-cycle pop does not return a credit until the next cycle.

Buffer and stream:
- Circular buffer, write on fifo_dout_valid, read on m_valid & m_ready.
- m_valid = occ != 0; m_data = head entry.
- Word order equals FIFO order.
- Latency: accepted ren at cycle t -> fifo_dout_valid at t+RD_LAT -> m_valid at t+RD_LAT+1.
- Steady state with m_ready=1 and a non-empty FIFO: one word per cycle.
- m_valid/m_data hold stable while m_valid & ~m_ready.

FSM states:
- IDLE: no issue. Go to RUN when rd_en=1.
- RUN: issue as above. Go to IDLE when rd_en=0; in-flight words still land and drain normally.
- FLUSH: entered from any state when flush=1, taking priority over rd_en.
  - Clear occ and buffer pointers on entry; m_valid=0.
  - Discard fifo_dout_valid words and stop issuing.
  - Leave when inflight==0 and flush=0: go to RUN if rd_en, else IDLE.

Boundary conditions:
- Overflow: fifo_dout_valid with occ==BUF_DEPTH and no pop sets ovf_err; the word is dropped. Unreachable by construction; the bench asserts it never fires.
- busy = (inflight != 0) | (occ != 0).
- Reset mid-operation: in-flight FIFO reads are forgotten. The system must reset the FIFO in the same cycle.

Decomposition:
- Package fifo_ctrl_pkg holds:
  - the rd_state_e enum {IDLE, RUN, FLUSH};
  - localparam RD_LAT_SDP=3;
  - a function cnt_w(depth) returning $clog2(depth+1).
- One sub-module, reg_fifo_buf (DW, BUF_DEPTH): register circular buffer with push, pop, clear, head data and occ. The controller holds the credit logic and the FSM.

Test Plan:
- Reset: drive rst for 2 cycles mid-stream -> next cycle all outputs 0, state IDLE, ovf_err=0.
- Single word: FIFO holds 1 word (0x155), rd_en=1, m_ready=1 -> one fifo_ren accepted at t, m_valid=1 with m_data=0x155 at t+4 for 1 cycle, busy low at t+5.
- Throughput: 20 words 0..19 preloaded, m_ready=1 -> m_valid continuous for 20 cycles, data 0..19 in order, no ovf_err.
- Backpressure: 20 words, m_ready=0 -> exactly 8 reads accepted, then fifo_ren=0, occ=8, fifo_data_avail=12. Raise m_ready -> remaining 12 delivered in order.
- Flush: 20 words, m_ready toggling, pulse flush after word 5 consumed -> m_valid=0 next cycle, in-flight returns discarded. After inflight=0 with rd_en=1, the next word delivered is the FIFO's next unread entry (not any flushed word).
- Enable gating: rd_en drops mid-stream -> fifo_ren=0 the next cycle, the ≤RD_LAT in-flight words still delivered. Re-raising rd_en resumes with no lost or duplicated words.
